// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I controller and its datapath:
// state encoding, opcodes and the mux/ALU select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        JAL     = 4'd10,
        ILLEGAL = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic alu_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mc_if.sv
// Memory handshake between the controller and the shared instruction/data memory.
interface mc_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decode plus whole-instruction legality check.
module mc_alu_decoder
    import mc_pkg::*;
#(
    parameter int BNE_EN = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_code,
    output logic       legal
);

    always_comb begin
        alu_code = ALU_ADD;
        case (funct3)
            3'b000:  alu_code = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_code = ALU_SLT;
            3'b110:  alu_code = ALU_OR;
            3'b111:  alu_code = ALU_AND;
            default: alu_code = ALU_ADD;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_JAL: legal = 1'b1;
            OP_R, OP_I:           legal = alu_funct3_ok(funct3);
            OP_BR:                legal = (funct3 == 3'b000) || (funct3 == 3'b001 && BNE_EN != 0);
            default:              legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with memory wait states, illegal-opcode pulse
// and a retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter int BNE_EN   = 1,
    parameter int CNT_W    = 32,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    mc_if.master                mem,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);

    state_t     state, next_state;
    logic [2:0] dec_alu, alu_sel;
    logic       legal, retire;

    mc_alu_decoder #(.BNE_EN(BNE_EN)) u_alu_dec (
        .op       (op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_code (dec_alu),
        .legal    (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (mem.mem_ready) next_state = DECODE;
            DECODE: begin
                if (!legal) next_state = ILLEGAL;
                else begin
                    case (op)
                        OP_LW, OP_SW: next_state = MEMADR;
                        OP_R:         next_state = EXECR;
                        OP_I:         next_state = EXECI;
                        OP_BR:        next_state = BRANCH;
                        OP_JAL:       next_state = JAL;
                        default:      next_state = ILLEGAL;
                    endcase
                end
            end
            MEMADR:                  next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem.mem_ready) next_state = MEMWB;
            MEMWR:  if (mem.mem_ready) next_state = FETCH;
            EXECR, EXECI, JAL:       next_state = ALUWB;
            MEMWB, ALUWB, BRANCH, ILLEGAL: next_state = FETCH;
            default:                 next_state = FETCH;
        endcase
    end

    // Moore decode; reset forces every strobe low even though state already reads FETCH.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.adr_src   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        imm_src       = IMM_I;
        alu_sel       = ALU_ADD;
        illegal       = 1'b0;
        retire        = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem.mem_req = 1'b1;
                    alu_src_a   = SRCA_PC;
                    alu_src_b   = SRCB_FOUR;
                    result_src  = RES_ALURESULT;
                    ir_write    = mem.mem_ready;
                    pc_write    = mem.mem_ready;
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                end
                MEMADR: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                end
                MEMRD: begin
                    mem.mem_req = 1'b1;
                    mem.adr_src = 1'b1;
                end
                MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                MEMWR: begin
                    mem.mem_req   = 1'b1;
                    mem.mem_write = 1'b1;
                    mem.adr_src   = 1'b1;
                    retire        = mem.mem_ready;
                end
                EXECR: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_RD2;
                    alu_sel   = dec_alu;
                end
                EXECI: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                    alu_sel   = dec_alu;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = SRCA_RD1;
                    alu_src_b = SRCB_RD2;
                    alu_sel   = ALU_SUB;
                    retire    = 1'b1;
                    pc_write  = (funct3 == 3'b000) ? zero : ~zero;
                end
                JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    assign alu_control = ALUCTL_W'(alu_sel);
    assign state_o     = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench: two controllers (BNE on / 4-bit counter, BNE off / widened ALU control)
// run in lockstep against an instruction-level reference model.
module tb_mc_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset, ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;

    always #5 clk = ~clk;

    mc_if bus0 ();
    mc_if bus1 ();
    assign bus0.mem_ready = ready;
    assign bus1.mem_ready = ready;

    logic       ir_write0, pc_write0, reg_write0, illegal0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0, imm_src0;
    logic [2:0] alu_control0;
    logic [3:0] retired0, state0;

    logic        ir_write1, pc_write1, reg_write1, illegal1;
    logic [1:0]  result_src1, alu_src_a1, alu_src_b1, imm_src1;
    logic [3:0]  alu_control1, state1;
    logic [31:0] retired1;

    mc_controller #(.BNE_EN(1), .CNT_W(4), .ALUCTL_W(3)) dut0 (
        .clk(clk), .reset(reset), .mem(bus0), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .ir_write(ir_write0), .pc_write(pc_write0), .reg_write(reg_write0),
        .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .imm_src(imm_src0), .alu_control(alu_control0), .illegal(illegal0),
        .retired(retired0), .state_o(state0)
    );

    mc_controller #(.BNE_EN(0), .CNT_W(32), .ALUCTL_W(4)) dut1 (
        .clk(clk), .reset(reset), .mem(bus1), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .ir_write(ir_write1), .pc_write(pc_write1), .reg_write(reg_write1),
        .result_src(result_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .imm_src(imm_src1), .alu_control(alu_control1), .illegal(illegal1),
        .retired(retired1), .state_o(state1)
    );

    typedef struct packed {
        logic [3:0]  state;
        logic        ir, pc, rw, req, mw, adr, ill;
        logic [1:0]  rs, a, b, imm;
        logic [3:0]  alu;
        logic [31:0] ret;
    } obs_t;

    obs_t obs0, obs1;
    assign obs0 = '{state: state0, ir: ir_write0, pc: pc_write0, rw: reg_write0,
                    req: bus0.mem_req, mw: bus0.mem_write, adr: bus0.adr_src, ill: illegal0,
                    rs: result_src0, a: alu_src_a0, b: alu_src_b0, imm: imm_src0,
                    alu: 4'(alu_control0), ret: 32'(retired0)};
    assign obs1 = '{state: state1, ir: ir_write1, pc: pc_write1, rw: reg_write1,
                    req: bus1.mem_req, mw: bus1.mem_write, adr: bus1.adr_src, ill: illegal1,
                    rs: result_src1, a: alu_src_a1, b: alu_src_b1, imm: imm_src1,
                    alu: alu_control1, ret: retired1};

    // Per-instruction expectation, counted in cycles after the fetch completes.
    typedef struct {
        int          post;
        int          wb_idx;
        logic [1:0]  wb_rs;
        int          pcw, ill, mreq, mwr;
        logic [2:0]  alu1;
        bit          alu1_chk;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        bit         active;
        int         idx, n_wb, wb_at, n_pcw, n_ill, n_mreq, n_mwr, n_badadr;
        logic [1:0] wb_rs;
        logic [2:0] alu1;
    } mon_t;

    exp_t        q [2][$];
    mon_t        mon [2];
    int unsigned m_ret [2];
    int          total = 0;
    int          bad   = 0;
    logic [2:0]  okf3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int w, input bit bne_en);
        exp_t e;
        bit   f3_ok = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
        e.post = 2; e.wb_idx = -1; e.wb_rs = 2'b00; e.pcw = 0; e.ill = 0;
        e.mreq = 0; e.mwr = 0; e.alu1 = 3'b000; e.alu1_chk = 1'b1; e.ret = '0;
        case (o)
            7'b0000011: begin e.post = 4 + w; e.wb_idx = 3 + w; e.wb_rs = 2'b01; e.mreq = w + 1; end
            7'b0100011: begin e.post = 3 + w; e.mreq = w + 1; e.mwr = w + 1; end
            7'b0110011, 7'b0010011: begin
                if (f3_ok) begin
                    e.post = 3; e.wb_idx = 2;
                    case (f3)
                        3'd0:    e.alu1 = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
                        3'd2:    e.alu1 = 3'b101;
                        3'd6:    e.alu1 = 3'b011;
                        default: e.alu1 = 3'b010;
                    endcase
                end else e.ill = 1;
            end
            7'b1100011: begin
                if (f3 == 0 || (f3 == 1 && bne_en)) begin
                    e.alu1 = 3'b001;
                    e.pcw  = (f3 == 0) ? int'(z) : int'(!z);
                end else e.ill = 1;
            end
            7'b1101111: begin e.post = 3; e.wb_idx = 2; e.pcw = 1; end
            default:    e.ill = 1;
        endcase
        if (e.ill != 0) begin e.post = 2; e.alu1_chk = 1'b0; end
        return e;
    endfunction

    // Drives one instruction: df idle fetch cycles, fetch handshake, then w wait cycles on any memory access.
    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int w, input int df);
        exp_t e;
        bit   is_mem;
        for (int d = 0; d < 2; d++) begin
            e = model(o, f3, f7, z, w, d == 0);
            if (e.ill == 0) m_ret[d] = (d == 0) ? (m_ret[d] + 1) % 16 : m_ret[d] + 1;
            e.ret = m_ret[d];
            q[d].push_back(e);
        end
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        is_mem = (o == OP_LW) || (o == OP_SW);
        repeat (df) begin ready = 1'b0; @(posedge clk); #1; end
        ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < e.post; i++) begin
            if (is_mem && i >= 2) ready = (i == 2 + w);
            else                  ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ready = 1'b0;
    endtask

    task automatic mon_step(input int d, input obs_t o);
        exp_t  e;
        string t = (d == 0) ? "d0" : "d1";
        if (reset) begin
            mon[d].active = 1'b0;
            return;
        end
        if (o.state == FETCH) begin
            if (mon[d].active) begin
                if (q[d].size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s_unexpected actual=instruction required=none", t);
                end else begin
                    e = q[d].pop_front();
                    chk({t, "_cycles"}, 64'(mon[d].idx), 64'(e.post));
                    chk({t, "_regwrite_cnt"}, 64'(mon[d].n_wb), (e.wb_idx >= 0) ? 64'd1 : 64'd0);
                    if (e.wb_idx >= 0) begin
                        chk({t, "_regwrite_at"}, 64'(mon[d].wb_at), 64'(e.wb_idx));
                        chk({t, "_wb_result_src"}, 64'(mon[d].wb_rs), 64'(e.wb_rs));
                    end
                    chk({t, "_pc_write_cnt"}, 64'(mon[d].n_pcw), 64'(e.pcw));
                    chk({t, "_illegal_cnt"}, 64'(mon[d].n_ill), 64'(e.ill));
                    chk({t, "_mem_req_cnt"}, 64'(mon[d].n_mreq), 64'(e.mreq));
                    chk({t, "_mem_write_cnt"}, 64'(mon[d].n_mwr), 64'(e.mwr));
                    chk({t, "_adr_src"}, 64'(mon[d].n_badadr), 64'd0);
                    if (e.alu1_chk) chk({t, "_alu_control"}, 64'(mon[d].alu1), 64'(e.alu1));
                    chk({t, "_retired"}, 64'(o.ret), 64'(e.ret));
                end
            end
            mon[d].active = 1'b0;
            if (ready) begin
                chk({t, "_fetch"}, 64'({o.ir, o.pc, o.rs, o.a, o.b, o.alu, o.req, o.adr}),
                    64'({1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 4'b0000, 1'b1, 1'b0}));
                mon[d] = '{active: 1'b1, default: 0};
            end else begin
                chk({t, "_fetch_idle"}, 64'({o.ir, o.pc, o.rw, o.mw, o.ill, o.req, o.adr}),
                    64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
            end
        end else if (mon[d].active) begin
            if (mon[d].idx == 0)
                chk({t, "_decode"}, 64'({o.a, o.b, o.imm, o.alu}), 64'({2'b01, 2'b01, 2'b10, 4'b0000}));
            if (o.rw) begin mon[d].n_wb++; mon[d].wb_at = mon[d].idx; mon[d].wb_rs = o.rs; end
            if (o.pc)  mon[d].n_pcw++;
            if (o.ill) mon[d].n_ill++;
            if (o.req) begin
                mon[d].n_mreq++;
                if (!o.adr) mon[d].n_badadr++;
            end
            if (o.mw) mon[d].n_mwr++;
            if (mon[d].idx == 1) mon[d].alu1 = o.alu[2:0];
            mon[d].idx++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, obs0);
        mon_step(1, obs1);
    end

    task automatic reset_checks(input string name);
        chk({name, "_state"}, 64'({state0, state1}), 64'({4'(FETCH), 4'(FETCH)}));
        chk({name, "_retired"}, 64'({retired0, retired1}), 64'd0);
        chk({name, "_strobes"}, 64'({bus0.mem_req, bus1.mem_req, ir_write0, pc_write0, reg_write0,
                                      ir_write1, pc_write1, reg_write1}), 64'd0);
    endtask

    initial begin
        logic [6:0] o;
        logic [2:0] f3;
        int         k;
        reset = 1'b0; ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        m_ret[0] = 0; m_ret[1] = 0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset_checks("reset");
        reset = 1'b0;

        issue(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);   // add x3,x1,x2
        issue(OP_LW, 3'b010, 1'b0, 1'b0, 3, 1);

        // lw abandoned mid-MEMRD by reset
        op = OP_LW; funct3 = 3'b010;
        ready = 1'b1; @(posedge clk); #1;
        ready = 1'b0; repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1; #1;
        reset_checks("abort");
        m_ret[0] = 0; m_ret[1] = 0;
        @(posedge clk); #1;
        reset = 1'b0;

        issue(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0);  // beq taken
        issue(OP_BR, 3'b001, 1'b0, 1'b1, 0, 1);  // bne not taken / illegal without BNE
        issue(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0);
        issue(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0);
        issue(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
        issue(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
        issue(OP_I, 3'b011, 1'b0, 1'b0, 0, 0);   // unsupported funct3
        for (int n = 0; n < 16; n++)
            issue(OP_R, okf3[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'b0, 0, 0);
        issue(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        issue(OP_SW, 3'b010, 1'b0, 1'b0, 2, 0);

        for (int n = 0; n < 120; n++) begin
            k  = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            case (k)
                0:       o = OP_LW;
                1:       o = OP_SW;
                2, 3:    o = OP_R;
                4, 5:    o = OP_I;
                6:       o = OP_BR;
                7:       o = OP_JAL;
                8:       o = 7'($urandom);
                default: o = 7'b0000000;
            endcase
            if (k >= 2 && k <= 5 && $urandom_range(0, 3) != 0) f3 = okf3[$urandom_range(0, 3)];
            if (k == 6 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
            issue(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 2));
        end

        ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("d0_queue_drained", 64'(q[0].size()), 64'd0);
        chk("d1_queue_drained", 64'(q[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
